// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-stage hazard inputs and control outputs for pipe_hazard_ctrl.
// The master side drives stage information; the slave (controller) drives controls.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] Rs1_D;
    logic [REG_AW-1:0] Rs2_D;
    logic [REG_AW-1:0] Rs1_E;
    logic [REG_AW-1:0] Rs2_E;
    logic [REG_AW-1:0] Rd_E;
    logic              Load_E;
    logic [REG_AW-1:0] Rd_M;
    logic              RegWrite_M;
    logic [REG_AW-1:0] Rd_W;
    logic              RegWrite_W;
    logic              PCSrc_E;
    logic              MulStart_E;

    logic [1:0]        ForwardA_E;
    logic [1:0]        ForwardB_E;
    logic              Stall_F;
    logic              Stall_D;
    logic              Stall_E;
    logic              Flush_D;
    logic              Flush_E;
    logic              Bubble_M;
    logic              Busy_E;
    logic [CNT_W-1:0]  StallCnt;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Load_E, Rd_M, RegWrite_M,
               Rd_W, RegWrite_W, PCSrc_E, MulStart_E,
        input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Flush_D,
               Flush_E, Bubble_M, Busy_E, StallCnt
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Load_E, Rd_M, RegWrite_M,
               Rd_W, RegWrite_W, PCSrc_E, MulStart_E,
        output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Flush_D,
               Flush_E, Bubble_M, Busy_E, StallCnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: forwarding, load-use stall, branch flush,
// multicycle-execute sequencing and a saturating fetch-stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int unsigned CW       = 4;
    localparam int unsigned CNT_LOAD = (MUL_LAT >= 2) ? (MUL_LAT - 2) : 0;
    localparam bit          MUL_EN   = (MUL_LAT >= 2);
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mstall;
    logic          lw;

    // Forwarding selects: M has priority over W, x0 never forwarded
    always_comb begin
        hz.ForwardA_E = 2'b00;
        hz.ForwardB_E = 2'b00;
        if (!rst) begin
            if (hz.RegWrite_M && hz.Rd_M != REG_ZERO && hz.Rd_M == hz.Rs1_E)
                hz.ForwardA_E = 2'b10;
            else if (hz.RegWrite_W && hz.Rd_W != REG_ZERO && hz.Rd_W == hz.Rs1_E)
                hz.ForwardA_E = 2'b01;
            if (hz.RegWrite_M && hz.Rd_M != REG_ZERO && hz.Rd_M == hz.Rs2_E)
                hz.ForwardB_E = 2'b10;
            else if (hz.RegWrite_W && hz.Rd_W != REG_ZERO && hz.Rd_W == hz.Rs2_E)
                hz.ForwardB_E = 2'b01;
        end
    end

    // Stall/flush decode, priority mstall > branch > load-use
    always_comb begin
        mstall      = 1'b0;
        lw          = 1'b0;
        hz.Stall_F  = 1'b0;
        hz.Stall_D  = 1'b0;
        hz.Stall_E  = 1'b0;
        hz.Flush_D  = 1'b0;
        hz.Flush_E  = 1'b0;
        hz.Bubble_M = 1'b0;
        hz.Busy_E   = 1'b0;
        if (!rst) begin
            if (state == IDLE) mstall = MUL_EN && hz.MulStart_E;
            else               mstall = (cnt != '0);
            lw = hz.Load_E && hz.Rd_E != REG_ZERO &&
                 (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D);
            hz.Busy_E = (state == BUSY) || mstall;
            if (mstall) begin
                hz.Stall_F  = 1'b1;
                hz.Stall_D  = 1'b1;
                hz.Stall_E  = 1'b1;
                hz.Bubble_M = 1'b1;
            end else if (hz.PCSrc_E) begin
                hz.Flush_D = 1'b1;
                hz.Flush_E = 1'b1;
            end else if (lw) begin
                hz.Stall_F = 1'b1;
                hz.Stall_D = 1'b1;
                hz.Flush_E = 1'b1;
            end
        end
    end

    // Multicycle sequencer; the release cycle (BUSY, cnt==0) ignores MulStart_E
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (mstall) begin
                    state <= BUSY;
                    cnt   <= CW'(CNT_LOAD);
                end
                BUSY: if (cnt != '0) cnt <= cnt - CW'(1);
                      else           state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                  hz.StallCnt <= '0;
        else if (hz.Stall_F && hz.StallCnt != CNT_MAX) hz.StallCnt <= hz.StallCnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations (MUL_LAT=4, CNT_W=16).
module tb_pipe_hazard_ctrl;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic clear_inputs();
        hz.Rs1_D = '0; hz.Rs2_D = '0; hz.Rs1_E = '0; hz.Rs2_E = '0;
        hz.Rd_E = '0;  hz.Load_E = 1'b0; hz.Rd_M = '0; hz.RegWrite_M = 1'b0;
        hz.Rd_W = '0;  hz.RegWrite_W = 1'b0; hz.PCSrc_E = 1'b0; hz.MulStart_E = 1'b0;
    endtask

    // Pack the 1-bit controls {Stall_F,Stall_D,Stall_E,Flush_D,Flush_E,Bubble_M,Busy_E}
    function automatic logic [6:0] ctl();
        return {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Flush_D, hz.Flush_E, hz.Bubble_M, hz.Busy_E};
    endfunction

    task automatic set_lu();
        hz.Load_E = 1'b1; hz.Rd_E = 5'd7; hz.Rs2_D = 5'd7;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Reset forces controls low even with hazards present
        hz.MulStart_E = 1'b1; hz.PCSrc_E = 1'b1; set_lu();
        hz.RegWrite_M = 1'b1; hz.Rd_M = 5'd5; hz.Rs1_E = 5'd5;
        #1;
        check("rst_ctl", 32'(ctl()), 32'h0);
        check("rst_fwdA", 32'(hz.ForwardA_E), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0; clear_inputs();
        #1;
        check("rst_cnt", 32'(hz.StallCnt), 32'h0);
        check("idle_ctl", 32'(ctl()), 32'h0);

        // Forwarding
        @(negedge clk);
        hz.RegWrite_M = 1'b1; hz.Rd_M = 5'd5; hz.RegWrite_W = 1'b1; hz.Rd_W = 5'd5;
        hz.Rs1_E = 5'd5; hz.Rs2_E = 5'd0;
        #1;
        check("fwdA_M", 32'(hz.ForwardA_E), 32'h2);
        check("fwdB_x0", 32'(hz.ForwardB_E), 32'h0);
        hz.Rd_M = 5'd0; #1;
        check("fwdA_W", 32'(hz.ForwardA_E), 32'h1);
        hz.Rd_M = 5'd5; hz.Rd_W = 5'd9; hz.Rs2_E = 5'd9; #1;
        check("fwdA_M2", 32'(hz.ForwardA_E), 32'h2);
        check("fwdB_W", 32'(hz.ForwardB_E), 32'h1);
        hz.RegWrite_M = 1'b0; hz.Rs1_E = 5'd5; #1;
        check("fwdA_none", 32'(hz.ForwardA_E), 32'h0);
        hz.Rs2_E = 5'd5; hz.RegWrite_M = 1'b1; hz.RegWrite_W = 1'b0; #1;
        check("fwdB_M", 32'(hz.ForwardB_E), 32'h2);

        // Load-use single cycle
        @(negedge clk);
        clear_inputs(); set_lu(); #1;
        check("lu_ctl", 32'(ctl()), 32'b1100100);
        @(negedge clk);
        clear_inputs(); #1;
        check("lu_cnt", 32'(hz.StallCnt), 32'd1);
        check("lu_off", 32'(ctl()), 32'h0);
        hz.Load_E = 1'b1; hz.Rd_E = 5'd0; #1;
        check("lu_x0", 32'(ctl()), 32'h0);
        @(negedge clk);
        clear_inputs(); #1;
        check("lu_x0_cnt", 32'(hz.StallCnt), 32'd1);

        // Branch overrides load-use
        set_lu(); hz.Rs1_D = 5'd7; hz.PCSrc_E = 1'b1; #1;
        check("br_ctl", 32'(ctl()), 32'b0001100);
        @(negedge clk);
        clear_inputs(); #1;
        check("br_cnt", 32'(hz.StallCnt), 32'd1);

        // Multicycle op with concurrent load-use during the stall cycles
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            hz.MulStart_E = 1'b1;
            if (i < 3) set_lu();
            #1;
            check($sformatf("mul_ctl%0d", i), 32'(ctl()), (i < 3) ? 32'b1110011 : 32'b0000001);
            @(negedge clk);
        end
        clear_inputs(); #1;
        check("mul_done", 32'(ctl()), 32'h0);
        check("mul_cnt", 32'(hz.StallCnt), 32'd4);

        // Reset during the second BUSY cycle, then a full restart
        @(negedge clk);
        hz.MulStart_E = 1'b1; #1;
        check("rm_c0", 32'(ctl()), 32'b1110011);
        @(negedge clk);
        rst = 1'b1; #1;
        check("rm_rst", 32'(ctl()), 32'h0);
        @(negedge clk);
        rst = 1'b0; #1;
        check("rm_cnt0", 32'(hz.StallCnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rm_ctl%0d", i), 32'(ctl()), (i < 3) ? 32'b1110011 : 32'b0000001);
            @(negedge clk);
            #1;
        end
        clear_inputs(); #1;
        check("rm_cnt3", 32'(hz.StallCnt), 32'd3);
        check("rm_idle", 32'(ctl()), 32'h0);

        // Saturation: 2^CNT_W + 5 load-use stall cycles
        set_lu();
        repeat ((1 << CNT_W) + 5) @(negedge clk);
        clear_inputs(); #1;
        check("sat_cnt", 32'(hz.StallCnt), 32'hFFFF);
        @(negedge clk);
        set_lu(); #1;
        @(negedge clk);
        clear_inputs(); #1;
        check("sat_hold", 32'(hz.StallCnt), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
